datapath_arbiter: RTL and testbench



---
 rtl/arb_pkg.sv | 14 +
 rtl/rr_pick.sv | 35 +++
 rtl/datapath_arbiter.sv | 112 +++++++++++
 tb/tb_datapath_arbiter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the datapath arbiter: FSM state encoding and default limits.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam int TIMEOUT_DEFAULT = 15;
    localparam int NUM_REQ_MAX     = 8;

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority encoder: finds the first asserted request at or above ptr, wrapping around.
module rr_pick
    import arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] pick,
    output logic [IDX_W-1:0]   idx,
    output logic               any_req
);

    // NOTE: every variable written here gets a default first so no latch is inferred.
    always_comb begin
        logic found;
        int   j;
        pick    = '0;
        idx     = '0;
        any_req = |req;
        found   = 1'b0;
        j       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(ptr) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!found && req[j]) begin
                found   = 1'b1;
                pick[j] = 1'b1;
                idx     = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/datapath_arbiter.sv
// Round-robin arbiter that shares one datapath between NUM_REQ requesters:
// grant, issue operand with a start pulse, wait for data_en (or timeout), pulse done.
module datapath_arbiter
    import arb_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = 1,
    parameter int TIMEOUT    = TIMEOUT_DEFAULT,
    parameter int CNT_W      = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clk_en,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            done,
    output logic                          timeout_err,
    output logic [DATA_WIDTH-1:0]         dp_data_in,
    output logic                          dp_start,
    input  logic                          dp_data_en,
    output logic                          busy
);

    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int LAST_I  = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LAST_I);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

    state_t               state;
    logic [IDX_W-1:0]     rr_ptr;
    logic [IDX_W-1:0]     gnt_idx;
    logic [CNT_W-1:0]     counter;

    logic [NUM_REQ-1:0]   pick;
    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_any;
    logic [DATA_WIDTH-1:0] pick_data;
    logic                 timeout_hit;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req     (req),
        .ptr     (rr_ptr),
        .pick    (pick),
        .idx     (pick_idx),
        .any_req (pick_any)
    );

    always_comb begin
        pick_data   = req_data[int'(pick_idx) * DATA_WIDTH +: DATA_WIDTH];
        timeout_hit = (TIMEOUT > 0) && (counter == TO_LAST);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            gnt         <= '0;
            gnt_idx     <= '0;
            done        <= '0;
            timeout_err <= 1'b0;
            dp_start    <= 1'b0;
            dp_data_in  <= '0;
            busy        <= 1'b0;
            rr_ptr      <= '0;
            counter     <= '0;
        end else if (clk_en) begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        state      <= ISSUE;
                        gnt        <= pick;
                        gnt_idx    <= pick_idx;
                        dp_data_in <= pick_data;
                        dp_start   <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                ISSUE: begin
                    state    <= WAIT;
                    dp_start <= 1'b0;
                    counter  <= '0;
                end
                WAIT: begin
                    counter <= counter + 1'b1;
                    // data_en takes precedence over a coincident timeout
                    if (dp_data_en) begin
                        state <= RELEASE;
                        done  <= gnt;
                    end else if (timeout_hit) begin
                        state       <= RELEASE;
                        done        <= gnt;
                        timeout_err <= 1'b1;
                    end
                end
                RELEASE: begin
                    state       <= IDLE;
                    gnt         <= '0;
                    done        <= '0;
                    timeout_err <= 1'b0;
                    busy        <= 1'b0;
                    rr_ptr      <= (gnt_idx == IDX_LAST) ? '0 : gnt_idx + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_datapath_arbiter.sv
// Self-checking bench for datapath_arbiter: transaction-level model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_datapath_arbiter;

    localparam int N  = 2;
    localparam int W  = 1;
    localparam int TO = 15;
    localparam int CW = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             clk_en;
    logic [N-1:0]     req;
    logic [N*W-1:0]   req_data;
    logic [N-1:0]     gnt;
    logic [N-1:0]     done;
    logic             timeout_err;
    logic [W-1:0]     dp_data_in;
    logic             dp_start;
    logic             dp_data_en;
    logic             busy;

    datapath_arbiter #(
        .NUM_REQ    (N),
        .DATA_WIDTH (W),
        .TIMEOUT    (TO),
        .CNT_W      (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .clk_en      (clk_en),
        .req         (req),
        .req_data    (req_data),
        .gnt         (gnt),
        .done        (done),
        .timeout_err (timeout_err),
        .dp_data_in  (dp_data_in),
        .dp_start    (dp_start),
        .dp_data_en  (dp_data_en),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: a transaction is "in flight" from grant until its release cycle ends.
    // age counts enabled cycles since the grant; waited counts cycles spent waiting.
    bit           m_active;
    bit           m_finishing;
    int           m_age;
    int           m_waited;
    int           m_owner;
    int           m_ptr;
    logic [N-1:0] e_gnt;
    logic [N-1:0] e_done;
    logic         e_to;
    logic         e_start;
    logic [W-1:0] e_din;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_finishing = 0; m_age = 0; m_waited = 0; m_owner = 0; m_ptr = 0;
        e_gnt = '0; e_done = '0; e_to = 0; e_start = 0; e_din = '0;
    endtask

    task automatic model_edge();
        if (rst) begin
            model_reset();
        end else if (clk_en) begin
            if (!m_active) begin
                for (int k = 0; k < N; k++) begin
                    int j;
                    j = (m_ptr + k) % N;
                    if (!m_active && req[j]) begin
                        m_active = 1; m_finishing = 0; m_age = 0; m_waited = 0; m_owner = j;
                        e_gnt = '0; e_gnt[j] = 1'b1;
                        e_din = req_data[j*W +: W];
                        e_start = 1'b1;
                    end
                end
            end else if (m_finishing) begin
                m_active = 0; m_finishing = 0;
                e_gnt = '0; e_done = '0; e_to = 1'b0;
                m_ptr = (m_owner + 1) % N;
            end else if (m_age == 0) begin
                m_age = 1;
                e_start = 1'b0;
            end else begin
                if (dp_data_en) begin
                    m_finishing = 1; e_done = e_gnt;
                end else if (TO > 0 && m_waited == TO - 1) begin
                    m_finishing = 1; e_done = e_gnt; e_to = 1'b1;
                end
                m_waited++;
                m_age++;
            end
        end
    endtask

    // One clock: model advances on the edge, DUT outputs compared half a cycle later.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("cycle_outputs",
              {22'd0, gnt, done, timeout_err, dp_start, dp_data_in, busy},
              {22'd0, e_gnt, e_done, e_to, e_start, e_din, logic'(m_active)});
    endtask

    task automatic wait_start(input string name);
        int n;
        n = 0;
        while (dp_start !== 1'b1 && n < 40) begin step(); n++; end
        if (dp_start !== 1'b1) check(name, 32'd0, 32'd1);
    endtask

    task automatic drain();
        int n;
        req = '0; dp_data_en = 1'b1; clk_en = 1'b1;
        n = 0;
        while (busy !== 1'b0 && n < 40) begin step(); n++; end
        check("drain_idle", {31'd0, busy}, 32'd0);
        dp_data_en = 1'b0;
    endtask

    initial begin
        int n;
        int seen;
        logic [N-1:0] grants [4];
        logic [N-1:0] alt_exp [4];
        alt_exp = '{2'b01, 2'b10, 2'b01, 2'b10};

        model_reset();
        rst = 1'b1; clk_en = 1'b1; req = '0; req_data = '0; dp_data_en = 1'b0;
        step(); step();
        check("reset_gnt",  {30'd0, gnt}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);

        // Basic transaction: requester 0 with operand 1
        rst = 1'b0; req = 2'b01; req_data = 2'b01;
        step();
        check("basic_gnt",   {30'd0, gnt}, 32'd1);
        check("basic_start", {31'd0, dp_start}, 32'd1);
        check("basic_din",   {31'd0, dp_data_in}, 32'd1);
        req = '0; req_data = 2'b10;
        step();
        check("basic_din_held", {31'd0, dp_data_in}, 32'd1);
        dp_data_en = 1'b1;
        step();
        check("basic_done", {30'd0, done}, 32'd1);
        dp_data_en = 1'b0;
        step();
        check("basic_release", {30'd0, gnt}, 32'd0);
        step();

        // Alternation with both requesting, from a fresh pointer
        rst = 1'b1; step(); rst = 1'b0;
        req = 2'b11; dp_data_en = 1'b1; seen = 0; n = 0;
        while (seen < 4 && n < 60) begin
            step(); n++;
            if (dp_start === 1'b1) begin
                grants[seen] = gnt;
                seen++;
                if (seen == 4) req = '0;
            end
        end
        check("alt_count", seen, 4);
        for (int i = 0; i < 4; i++) check("alt_grant", {30'd0, grants[i]}, {30'd0, alt_exp[i]});
        drain();

        // Timeout: done 16 cycles after dp_start, then the other requester wins
        req = 2'b01; dp_data_en = 1'b0;
        wait_start("to_start");
        n = 0;
        while (done === '0 && n < 40) begin step(); n++; end
        check("to_latency", n, 16);
        check("to_err", {31'd0, timeout_err}, 32'd1);
        req = 2'b11;
        wait_start("to_next_start");
        check("to_next_gnt", {30'd0, gnt}, 32'd2);
        drain();

        // Stall of 5 cycles during WAIT pushes the timeout out by 5
        req = 2'b01; dp_data_en = 1'b0;
        wait_start("stall_start");
        n = 0;
        while (done === '0 && n < 60) begin
            clk_en = !(n >= 2 && n < 7);
            step(); n++;
        end
        clk_en = 1'b1;
        check("stall_latency", n, 21);
        check("stall_err", {31'd0, timeout_err}, 32'd1);
        drain();

        // Reset in WAIT: everything clears, requester 0 regranted first
        req = 2'b11; dp_data_en = 1'b0;
        wait_start("rst_start");
        step(); step();
        rst = 1'b1; step(); rst = 1'b0;
        check("rst_outputs", {26'd0, gnt, done, timeout_err, busy}, 32'd0);
        wait_start("rst_regrant");
        check("rst_regrant_gnt", {30'd0, gnt}, 32'd1);
        drain();

        // data_en during ISSUE ignored; data_en at the timeout threshold wins
        req = 2'b01; dp_data_en = 1'b0;
        wait_start("race_start");
        req = '0; n = 0;
        while (done === '0 && n < 40) begin
            dp_data_en = (n == 0) || (n == 15);
            step(); n++;
        end
        dp_data_en = 1'b0;
        check("race_latency", n, 16);
        check("race_done", {30'd0, done}, 32'd1);
        check("race_err", {31'd0, timeout_err}, 32'd0);
        drain();

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            req        = N'($urandom);
            req_data   = (N*W)'($urandom);
            dp_data_en = ($urandom_range(0, 7) == 0);
            clk_en     = ($urandom_range(0, 9) != 0);
            rst        = ($urandom_range(0, 199) == 0);
            step();
        end
        rst = 1'b0;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
